// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and the memory
// controller. The arbiter connects through the master modport. The requesters
// and the memory controller (or a bench) connect through the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int TRD_W  = 3
);
  // I-side requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [TRD_W-1:0]  i_trd;
  logic              i_gnt;
  logic              i_done;
  // D-side requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [TRD_W-1:0]  d_trd;
  logic              d_gnt;
  logic              d_done;
  // memory controller
  logic              ready;
  logic              tx_done;
  logic [1:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [TRD_W-1:0]  mem_trd;
  // status
  logic              busy;
  logic              err;

  modport master (
    input  i_req, i_addr, i_trd,
    input  d_req, d_we, d_addr, d_trd,
    input  ready, tx_done,
    output i_gnt, i_done, d_gnt, d_done,
    output mem_op, mem_addr, mem_trd, busy, err
  );

  modport slave (
    output i_req, i_addr, i_trd,
    output d_req, d_we, d_addr, d_trd,
    output ready, tx_done,
    input  i_gnt, i_done, d_gnt, d_done,
    input  mem_op, mem_addr, mem_trd, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between the I-side and the
// D-side cache controllers. D-side wins by default. The I-side is forced to
// win after STARVE_LIMIT consecutive lost arbitrations. Each op runs
// IDLE (grant) -> ISSUE (mem_op driven until ready) -> WAIT (until tx_done).
// The done pulse falls in the next IDLE cycle, so a new grant can share that
// cycle with the done pulse.
// Optional build macro MEM_TIMEOUT_EN adds a watchdog that aborts an op after
// TIMEOUT_CYC cycles in ISSUE+WAIT. The abort pulses err together with the
// owner's done. Without the macro, err is tied low.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int TRD_W        = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 1024
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TRD_W-1:0]  trd_q, trd_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  // bit 0 = I-side done, bit 1 = D-side done
  logic [1:0]        done_q, done_d;
  logic              i_gnt_c, d_gnt_c;
  logic              pick_i;

`ifdef MEM_TIMEOUT_EN
  localparam int              TC_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TIMEOUT_CYC - 1);
  logic [TC_W-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
`endif

  // Next-state, arbitration and latch-update logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    trd_d    = trd_q;
    starve_d = starve_q;
    done_d   = 2'b00;
    i_gnt_c  = 1'b0;
    d_gnt_c  = 1'b0;
    // The I-side takes the slot when it is alone or has lost too often.
    pick_i   = bus_if.i_req && (!bus_if.d_req || (starve_q == STARVE_MAX));
`ifdef MEM_TIMEOUT_EN
    err_d    = 1'b0;
    // The budget covers ISSUE and WAIT together. It saturates so that a late
    // ISSUE exit still leaves WAIT with an expired budget.
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TC_W'(1);
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Gating with rst_n keeps grants low while reset is held.
        if (rst_n && (bus_if.i_req || bus_if.d_req)) begin
          state_d = ST_ISSUE;
          if (pick_i) begin
            i_gnt_c  = 1'b1;
            owner_d  = OWN_I;
            we_d     = 1'b0;
            addr_d   = bus_if.i_addr;
            trd_d    = bus_if.i_trd;
            starve_d = '0;
          end else begin
            d_gnt_c = 1'b1;
            owner_d = OWN_D;
            we_d    = bus_if.d_we;
            addr_d  = bus_if.d_addr;
            trd_d   = bus_if.d_trd;
            if (bus_if.i_req && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + SC_W'(1);
            end
          end
        end
      end

      ST_ISSUE: begin
        // tx_done has no meaning until the op has been accepted.
        if (bus_if.ready) begin
          state_d = ST_WAIT;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          done_d  = (owner_q == OWN_D) ? 2'b10 : 2'b01;
          err_d   = 1'b1;
        end
`endif
      end

      ST_WAIT: begin
        // ready is ignored here. Only completion matters.
        if (bus_if.tx_done) begin
          state_d = ST_IDLE;
          done_d  = (owner_q == OWN_D) ? 2'b10 : 2'b01;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          done_d  = (owner_q == OWN_D) ? 2'b10 : 2'b01;
          err_d   = 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and op-latch registers. Reset abandons any op without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      trd_q    <= '0;
      starve_q <= '0;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      trd_q    <= trd_d;
      starve_q <= starve_d;
      done_q   <= done_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Watchdog counter and its error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus_if.err = err_q;
`else
  // The timeout limit has no role when the watchdog is absent.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign bus_if.err = 1'b0;
`endif

  assign bus_if.i_gnt    = i_gnt_c;
  assign bus_if.d_gnt    = d_gnt_c;
  assign bus_if.i_done   = done_q[0];
  assign bus_if.d_done   = done_q[1];
  assign bus_if.mem_op   = (state_q != ST_ISSUE) ? 2'b00 :
                           ((owner_q == OWN_D) && we_q) ? 2'b11 : 2'b01;
  assign bus_if.mem_addr = addr_q;
  assign bus_if.mem_trd  = trd_q;
  assign bus_if.busy     = (state_q != ST_IDLE);

endmodule
